// File: rtl/pad_frame_reader_pkg.sv
// Shared constants and helpers for the padded frame reader: FSM encoding,
// padded-geometry derivation and counter sizing.
package pad_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic int out_w(input int img_w, input int pad);
    return img_w + 2 * pad;
  endfunction

  function automatic int out_h(input int img_h, input int pad);
    return img_h + 2 * pad;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pad_frame_reader_if.sv
// Pixel-memory read port and padded output stream of the frame reader.
interface pad_frame_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last_col;
  logic              out_last_row;

  modport master (
    output rd_en, rd_addr, out_valid, out_data, out_last_col, out_last_row,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data, out_last_col, out_last_row,
    output rd_data, out_ready
  );

endinterface

// File: rtl/pad_frame_reader_sync_fifo.sv
// Small synchronous FIFO with occupancy count; any depth, not only powers of two.
module sync_fifo
  import pad_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = cnt_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: the storage array has no reset; only pointers and count need one, and
  // leaving it out keeps the array mappable to plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pad_frame_reader.sv
// Streams an IMG_H x IMG_W pixel map out of memory as a zero-padded frame
// on a valid/ready interface, one element per cycle when unstalled.
module pad_frame_reader
  import pad_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 18,
  parameter int IMG_W      = 416,
  parameter int IMG_H      = 416,
  parameter int PAD        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  pad_frame_reader_if.master   bus,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_W = out_w(IMG_W, PAD);
  localparam int OUT_H = out_h(IMG_H, PAD);
  localparam int ROW_W = cnt_w(OUT_H);
  localparam int COL_W = cnt_w(OUT_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = DATA_W + 2;

  logic [1:0]        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic              pipe_pad_q, pipe_pad_d;
  logic              pipe_last_col_q, pipe_last_col_d;
  logic              pipe_last_row_q, pipe_last_row_d;

  logic              issue, interior, at_last_col, at_last_row;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  // Leave one FIFO slot free for the element already sitting in the pipe stage.
  assign issue = (state_q == S_RUN) &&
                 ((int'(fifo_count) + int'(pipe_valid_q)) < (FIFO_DEPTH - 1));

  assign interior = (int'(row_q) >= PAD) && (int'(row_q) < PAD + IMG_H) &&
                    (int'(col_q) >= PAD) && (int'(col_q) < PAD + IMG_W);

  assign at_last_col = (col_q == COL_W'(OUT_W - 1));
  assign at_last_row = (row_q == ROW_W'(OUT_H - 1));

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    col_d           = col_q;
    addr_d          = addr_q;
    rd_addr_d       = rd_addr_q;
    pipe_valid_d    = issue;
    pipe_pad_d      = pipe_pad_q;
    pipe_last_col_d = pipe_last_col_q;
    pipe_last_row_d = pipe_last_row_q;

    if (issue) begin
      pipe_pad_d      = !interior;
      pipe_last_col_d = at_last_col;
      pipe_last_row_d = at_last_row;
      if (interior) begin
        addr_d    = addr_q + ADDR_W'(1);
        rd_addr_d = addr_q;
      end
      if (at_last_col) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        if (issue && at_last_col && at_last_row) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pipe_valid_q && fifo_empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      col_q           <= '0;
      addr_q          <= '0;
      rd_addr_q       <= '0;
      pipe_valid_q    <= 1'b0;
      pipe_pad_q      <= 1'b0;
      pipe_last_col_q <= 1'b0;
      pipe_last_row_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      addr_q          <= addr_d;
      rd_addr_q       <= rd_addr_d;
      pipe_valid_q    <= pipe_valid_d;
      pipe_pad_q      <= pipe_pad_d;
      pipe_last_col_q <= pipe_last_col_d;
      pipe_last_row_q <= pipe_last_row_d;
    end
  end

  // Memory data lands one cycle after rd_en, exactly when the pipe stage writes.
  assign fifo_push  = pipe_valid_q;
  assign fifo_wdata = {pipe_last_row_q, pipe_last_col_q,
                       pipe_pad_q ? {DATA_W{1'b0}} : bus.rd_data};

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rd_en   = issue && interior;
  assign bus.rd_addr = bus.rd_en ? addr_q : rd_addr_q;

  // Mask the unreset storage so the stream outputs read 0 whenever empty.
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign bus.out_last_col = !fifo_empty && fifo_rdata[DATA_W];
  assign bus.out_last_row = !fifo_empty && fifo_rdata[DATA_W+1];
  assign fifo_pop         = bus.out_valid && bus.out_ready;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_pad_frame_reader.sv
// Directed bench: 3x3 PAD=1 frames (free-running, backpressured, aborted,
// restarted) and a 2x2 PAD=0 frame from a non-zero base address.
module tb_pad_frame_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [17:0] base_a, base_b;
  logic        busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  bit ovf_seen = 1'b0;

  int exp_a [25] = '{0, 0, 0, 0, 0,
                     0, 1, 2, 3, 0,
                     0, 4, 5, 6, 0,
                     0, 7, 8, 9, 0,
                     0, 0, 0, 0, 0};
  int exp_b_addr [4] = '{100, 101, 102, 103};
  int exp_b_data [4] = '{101, 102, 103, 104};
  bit ready_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pad_frame_reader_if #(.DATA_W(8), .ADDR_W(18)) bus_a ();
  pad_frame_reader_if #(.DATA_W(8), .ADDR_W(18)) bus_b ();

  pad_frame_reader #(
    .DATA_W(8), .ADDR_W(18), .IMG_W(3), .IMG_H(3), .PAD(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .base_addr(base_a),
    .bus(bus_a), .busy(busy_a), .done(done_a)
  );

  pad_frame_reader #(
    .DATA_W(8), .ADDR_W(18), .IMG_W(2), .IMG_H(2), .PAD(0), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .base_addr(base_b),
    .bus(bus_b), .busy(busy_b), .done(done_b)
  );

  // Pixel memory: mem[a] = a + 1, one-cycle read latency.
  always @(posedge clk) begin
    if (bus_a.rd_en) bus_a.rd_data <= 8'(bus_a.rd_addr + 18'd1);
    if (bus_b.rd_en) bus_b.rd_data <= 8'(bus_b.rd_addr + 18'd1);
  end

  always @(posedge clk) begin
    if (dut_a.fifo_push && dut_a.fifo_full) ovf_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      busy_a, 0);
    check({tag, "_done"},      done_a, 0);
    check({tag, "_valid"},     bus_a.out_valid, 0);
    check({tag, "_rd_en"},     bus_a.rd_en, 0);
    check({tag, "_rd_addr"},   bus_a.rd_addr, 0);
    check({tag, "_data"},      bus_a.out_data, 0);
    check({tag, "_last_col"},  bus_a.out_last_col, 0);
    check({tag, "_last_row"},  bus_a.out_last_row, 0);
  endtask

  // One 3x3 PAD=1 frame on dut_a. toggle: ready pattern 1,0,0,1.
  // abort_at > 0: reset after that many handshakes. restart_at > 0: extra start then.
  task automatic run_a(input bit toggle, input int abort_at, input int restart_at);
    int cyc = 0, hs = 0, rds = 0, dones = 0;
    int first_cyc = 0, last_cyc = 0, done_cyc = 0;
    bit held = 1'b0, restarted = 1'b0, stop = 1'b0;
    logic [7:0] held_data = '0;
    logic held_lc = 1'b0, held_lr = 1'b0;

    @(negedge clk);
    base_a  = 18'd0;
    start_a = 1'b1;
    while (!stop) begin
      @(negedge clk);
      start_a = 1'b0;
      cyc++;
      bus_a.out_ready = toggle ? ready_pat[(cyc - 1) % 4] : 1'b1;
      if (restart_at > 0 && !restarted && hs == restart_at) begin
        start_a   = 1'b1;
        base_a    = 18'd50;
        restarted = 1'b1;
      end
      #1;
      if (bus_a.rd_en) rds++;
      if (done_a) begin
        dones++;
        done_cyc = cyc;
      end
      if (bus_a.out_valid) begin
        if (held) begin
          check("stall_data",     bus_a.out_data, held_data);
          check("stall_last_col", bus_a.out_last_col, held_lc);
          check("stall_last_row", bus_a.out_last_row, held_lr);
        end
        if (bus_a.out_ready) begin
          if (hs < 25) begin
            check("a_data",     bus_a.out_data, exp_a[hs]);
            check("a_last_col", bus_a.out_last_col, (hs % 5) == 4);
            check("a_last_row", bus_a.out_last_row, hs >= 20);
          end else begin
            check("a_extra_handshake", hs, 24);
          end
          if (hs == 0) first_cyc = cyc;
          last_cyc = cyc;
          hs++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = bus_a.out_data;
          held_lc   = bus_a.out_last_col;
          held_lr   = bus_a.out_last_row;
        end
      end
      if (abort_at > 0 && hs == abort_at) begin
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        stop = 1'b1;
      end else if (dones > 0 && cyc >= done_cyc + 4) begin
        stop = 1'b1;
      end else if (cyc >= 400) begin
        check("frame_timeout_done", dones, 1);
        stop = 1'b1;
      end
    end

    if (abort_at == 0) begin
      check("a_handshakes",    hs, 25);
      check("a_reads",         rds, 9);
      check("a_done_pulses",   dones, 1);
      check("a_done_after_last", done_cyc > last_cyc, 1);
      check("a_busy_after",    busy_a, 0);
      if (!toggle) begin
        check("a_first_cycle",  first_cyc, 3);
        check("a_stream_span",  last_cyc - first_cyc, 24);
      end
    end else begin
      check("abort_handshakes", hs, abort_at);
      check("abort_no_done",    dones, 0);
    end
  endtask

  // One 2x2 PAD=0 frame on dut_b from base 100.
  task automatic run_b();
    int nrd = 0, nhs = 0, dones = 0;
    @(negedge clk);
    base_b  = 18'd100;
    start_b = 1'b1;
    for (int c = 0; c < 100 && dones == 0; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      if (bus_b.rd_en) begin
        if (nrd < 4) check("b_rd_addr", bus_b.rd_addr, exp_b_addr[nrd]);
        nrd++;
      end
      if (bus_b.out_valid) begin
        if (nhs < 4) begin
          check("b_data",     bus_b.out_data, exp_b_data[nhs]);
          check("b_last_col", bus_b.out_last_col, (nhs % 2) == 1);
          check("b_last_row", bus_b.out_last_row, nhs >= 2);
        end
        nhs++;
      end
      if (done_b) dones++;
    end
    check("b_reads",      nrd, 4);
    check("b_handshakes", nhs, 4);
    check("b_done",       dones, 1);
  endtask

  initial begin
    int dones = 0, valids = 0;
    reset_n         = 1'b0;
    start_a         = 1'b0;
    start_b         = 1'b0;
    base_a          = '0;
    base_b          = '0;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run_a(1'b0, 0, 0);
    run_a(1'b1, 0, 0);
    run_a(1'b0, 7, 0);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (done_a) dones++;
      if (bus_a.out_valid || busy_a) valids++;
    end
    check("post_abort_done",   dones, 0);
    check("post_abort_active", valids, 0);

    run_a(1'b1, 0, 5);
    run_b();
    check("fifo_overflow", ovf_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_frame_reader.md
Name: pad_frame_reader

Overview:
- Reads an unpadded IMG_H x IMG_W feature map from on-chip pixel memory in raster order.
- Emits the zero-padded frame, (IMG_H+2*PAD) x (IMG_W+2*PAD), as a valid/ready stream.
- Read-side partner of the padding write path: it produces the padded stream that downstream conv windows consume.
- Default geometry: 416x416 YOLO input, PAD=1, giving a 418x418 output.

Parameters:
- DATA_W, 8, pixel width
- ADDR_W, 18, pixel memory address width
- IMG_W, 416, unpadded columns
- IMG_H, 416, unpadded rows
- PAD, 1, border width on each side; valid range 0..3
- FIFO_DEPTH, 4, output buffer depth; minimum 3

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a frame; ignored while busy=1
- base_addr  in  ADDR_W  memory address of pixel (0,0); sampled when start is accepted
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  DATA_W  memory data; valid exactly 1 cycle after rd_en
- out_valid  out  1  output element available
- out_ready  in  1  downstream accepts the element
- out_data  out  DATA_W  pixel value, or 0 for padding
- out_last_col  out  1  element is in output column OUT_W-1
- out_last_row  out  1  element is in output row OUT_H-1
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final element's handshake

Behaviour:
- Derived sizes: OUT_W = IMG_W + 2*PAD, OUT_H = IMG_H + 2*PAD.
- Reset values: all outputs 0; FSM in IDLE; counters, pipe stage and FIFO empty.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced; the FIFO contents are discarded.
- FSM:
  - IDLE: start=1 -> RUN. Load base_addr, row=0, col=0.
  - RUN: on each issue, col advances. At col=OUT_W-1, col wraps to 0 and row increments. Issuing (OUT_H-1, OUT_W-1) -> DRAIN.
  - DRAIN: waits until the pipe stage and FIFO are empty and the last element has handshaken -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy = 1 in RUN, DRAIN and DONE.
- Issue condition: in RUN and (fifo_count + pipe_valid) < FIFO_DEPTH-1. This sustains 1 element/cycle while out_ready stays high.
- Interior test: PAD <= row < PAD+IMG_H and PAD <= col < PAD+IMG_W.
  - Interior issue: rd_en=1 and rd_addr = running address. The running address starts at base_addr and increments by 1 per interior issue; no multiplier is used.
  - Border issue: rd_en=0 and rd_addr holds its value.
- Pipe stage: one register holding {valid, is_pad, last_col, last_row}. On the next cycle it writes the FIFO with data = is_pad ? 0 : rd_data. Pad and pixel elements therefore share the same 1-cycle latency, so ordering is preserved.
- FIFO: data plus last_col and last_row.
  - out_valid = (fifo_count != 0).
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - A push is never attempted when full; the issue rule guarantees this.
- Latency: start sampled at edge E0; first issue at E1; FIFO written at E2; out_valid=1 after E2.
- out_data and the last flags are stable while out_valid=1 and out_ready=0.
- Total handshakes per frame: exactly OUT_W*OUT_H. Memory reads per frame: exactly IMG_W*IMG_H.
- PAD=0: output equals the raw image, with no zero elements.
- start during busy: ignored, and base_addr is not re-sampled.

Decomposition:
- Package pad_pkg:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE)
  - OUT_W/OUT_H derivation functions
  - clog2-based counter widths for row/col
- Sub-module sync_fifo:
  - parameterised DATA_W+2 bits by FIFO_DEPTH
  - outputs count, full, empty
- Counters, address generator and FSM live in pad_frame_reader.

Test Plan:
- Small image, out_ready held high. IMG_W=IMG_H=3, PAD=1, memory[a]=a+1, base_addr=0, start pulse.
  - Expect 25 elements: row 0 all 0; row 1 = 0,1,2,3,0; row 2 = 0,4,5,6,0; row 3 = 0,7,8,9,0; row 4 all 0.
  - One element per cycle from 2 cycles after start.
  - done pulses once; 9 rd_en pulses total.
- Backpressure: same setup with out_ready toggling 1,0,0,1 repeatedly.
  - Identical 25-element sequence; out_data stable across stalls.
  - FIFO never overflows (assertion).
  - done pulses after the 25th handshake.
- Boundary flags: with the same setup, check flag positions.
  - out_last_col=1 on elements 5,10,15,20,25.
  - out_last_row=1 on elements 21..25 only.
- Non-zero base and PAD=0: IMG 2x2, base_addr=100.
  - rd_addr sequence is 100,101,102,103; output is memory[100..103].
  - No zeros inserted.
- Reset and start handling:
  - Assert reset_n=0 after the 7th handshake. All outputs go to 0 immediately and busy=0; no done pulse follows.
  - A start after reset runs a full clean 25-element frame.
  - A second start pulsed mid-frame has no effect.
